// File: rtl/led_report_pkg.sv
// Shared definitions for the LED count UART reporter.
// ASCII constants, FSM state encodings and the nibble-to-hex helper.
package led_report_pkg;

    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_A  = 8'h41;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } top_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    // 0-9 -> '0'..'9', 10-15 -> 'A'..'F'
    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
        logic [7:0] n8;
        n8 = {4'h0, nib};
        if (nib < 4'd10) begin
            return ASCII_0 + n8;
        end
        return ASCII_A + n8 - 8'd10;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 UART byte transmitter, LSB first, idle high.
// Ports: clk, rst (sync, active high), start/data (accepted when ready),
//        tx (serial line), ready (can take a byte this cycle),
//        done (one-cycle pulse on the last cycle of the stop bit).
module uart_tx_byte
    import led_report_pkg::*;
#(
    parameter int CLK_FREQ = 25_000_000,
    parameter int BAUD     = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       ready,
    output logic       done
);

    localparam int          BIT_CYCLES = CLK_FREQ / BAUD;
    localparam logic [31:0] LAST       = 32'(BIT_CYCLES - 1);
    localparam logic [31:0] PRE_LAST   = 32'(BIT_CYCLES - 2);

    tx_state_t   state;
    logic [31:0] baud_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic        bit_end;

    assign bit_end = (baud_cnt == LAST);

    // Ready in the final stop-bit cycle lets the next byte follow with no gap.
    assign ready = (state == TX_IDLE) || ((state == TX_STOP) && bit_end);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= TX_IDLE;
            tx       <= 1'b1;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                TX_IDLE: begin
                    if (start) begin
                        state    <= TX_START;
                        tx       <= 1'b0;
                        shreg    <= data;
                        baud_cnt <= '0;
                    end
                end
                TX_START: begin
                    if (bit_end) begin
                        state    <= TX_DATA;
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        tx       <= shreg[0];
                    end else begin
                        baud_cnt <= baud_cnt + 32'd1;
                    end
                end
                TX_DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= TX_STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shreg[1];
                            shreg   <= {1'b0, shreg[7:1]};
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 32'd1;
                    end
                end
                TX_STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (start) begin
                            state <= TX_START;
                            tx    <= 1'b0;
                            shreg <= data;
                        end else begin
                            state <= TX_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 32'd1;
                        // Registered so it is high exactly while baud_cnt == LAST.
                        done     <= (baud_cnt == PRE_LAST);
                    end
                end
                default: state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/led_uart_reporter.sv
// Reports every change of the 8-bit LED count as two ASCII hex chars over UART.
// Ports: clk, rst (sync, active high), value[7:0] (count to watch),
//        tx (UART line), busy (frame in flight), frame_done (end of frame pulse).
// Option: define LED_REPORT_CRLF_EN to append CR LF to every frame.
module led_uart_reporter
    import led_report_pkg::*;
#(
    parameter int CLK_FREQ = 25_000_000,
    parameter int BAUD     = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] value,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

`ifdef LED_REPORT_CRLF_EN
    localparam int                 IDX_W    = 2;
    localparam logic [IDX_W-1:0]   LAST_IDX = 2'd3;
`else
    localparam int                 IDX_W    = 1;
    localparam logic [IDX_W-1:0]   LAST_IDX = 1'd1;
`endif

    top_state_t       state;
    logic             pending;
    logic [7:0]       snapshot;
    logic [7:0]       last_seen;
    logic [IDX_W-1:0] char_idx;
    logic             last_issued;
    logic             changed;
    logic             restart;
    logic             start;
    logic [7:0]       char_data;
    logic             tx_ready;
    logic             tx_done;

    assign changed    = (value != last_seen);
    assign frame_done = (state == ST_SEND) && tx_done && last_issued;

    // A pending change at the end of a frame snapshots the live value and
    // launches its high nibble in the same cycle, so frames abut.
    assign restart = frame_done && pending;
    assign start   = restart ||
                     ((state == ST_SEND) && tx_ready && !last_issued);

    always_comb begin
        char_data = nibble_to_ascii(snapshot[7:4]);
        if (restart) begin
            char_data = nibble_to_ascii(value[7:4]);
        end else begin
            case (char_idx)
                IDX_W'(0): char_data = nibble_to_ascii(snapshot[7:4]);
                IDX_W'(1): char_data = nibble_to_ascii(snapshot[3:0]);
`ifdef LED_REPORT_CRLF_EN
                IDX_W'(2): char_data = ASCII_CR;
                IDX_W'(3): char_data = ASCII_LF;
`endif
                default:   char_data = nibble_to_ascii(snapshot[7:4]);
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            pending     <= 1'b1;
            snapshot    <= '0;
            last_seen   <= '0;
            char_idx    <= '0;
            last_issued <= 1'b0;
        end else begin
            last_seen <= value;
            case (state)
                ST_IDLE: begin
                    if (pending) begin
                        // A change this same cycle is captured here.
                        snapshot    <= value;
                        pending     <= 1'b0;
                        busy        <= 1'b1;
                        state       <= ST_SEND;
                        char_idx    <= '0;
                        last_issued <= 1'b0;
                    end else if (changed) begin
                        pending <= 1'b1;
                    end
                end
                ST_SEND: begin
                    if (frame_done) begin
                        if (pending) begin
                            snapshot    <= value;
                            pending     <= 1'b0;
                            char_idx    <= IDX_W'(1);
                            last_issued <= 1'b0;
                        end else begin
                            state       <= ST_IDLE;
                            busy        <= 1'b0;
                            char_idx    <= '0;
                            last_issued <= 1'b0;
                            pending     <= changed;
                        end
                    end else begin
                        if (changed) begin
                            pending <= 1'b1;
                        end
                        if (start) begin
                            char_idx <= char_idx + IDX_W'(1);
                            if (char_idx == LAST_IDX) begin
                                last_issued <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    uart_tx_byte #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) u_tx (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .data  (char_data),
        .tx    (tx),
        .ready (tx_ready),
        .done  (tx_done)
    );

endmodule

// File: tb/tb_led_uart_reporter.sv
// Self-checking bench for led_uart_reporter (CLK_FREQ=1000, BAUD=100).
// Works with or without LED_REPORT_CRLF_EN defined.
module tb_led_uart_reporter;

    localparam int CLK_FREQ = 1000;
    localparam int BAUD     = 100;
    localparam int BC       = CLK_FREQ / BAUD;
`ifdef LED_REPORT_CRLF_EN
    localparam int NCH = 4;
`else
    localparam int NCH = 2;
`endif
    localparam int FLEN = NCH * 10 * BC;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] value = 8'h00;
    logic       tx;
    logic       busy;
    logic       frame_done;

    always #5 clk = ~clk;

    led_uart_reporter #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .value      (value),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    int         checks = 0;
    int         errors = 0;
    int         wave_pos = -1;
    bit         exp_more = 1'b0;

    typedef struct {
        logic [7:0] v;
        logic [7:0] hi;
        logic [7:0] lo;
    } vec_t;

    // UART monitor: samples each bit in its middle.
    logic [7:0] rx_q[$];
    bit         mon_act = 1'b0;
    int         mon_t = 0;
    logic [7:0] mon_sh = 8'h00;
    int         mon_bad = 0;

    always @(negedge clk) begin
        if (rst) begin
            mon_act <= 1'b0;
        end else if (!mon_act) begin
            if (tx === 1'b0) begin
                mon_act <= 1'b1;
                mon_t   <= 1;
            end
        end else begin
            mon_t <= mon_t + 1;
            if (mon_t % BC == BC / 2) begin
                if (mon_t / BC == 0) begin
                    if (tx !== 1'b0) mon_bad <= mon_bad + 1;
                end else if (mon_t / BC <= 8) begin
                    mon_sh <= {tx, mon_sh[7:1]};
                end else begin
                    if (tx !== 1'b1) mon_bad <= mon_bad + 1;
                    rx_q.push_back(mon_sh);
                    mon_act <= 1'b0;
                end
            end
        end
    end

    function automatic logic [7:0] hexc(input logic [3:0] n);
        if (n < 4'd10) return 8'h30 + 8'(n);
        return 8'h41 + 8'(n) - 8'd10;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", nm, got, exp);
        end
    endtask

    task automatic check_bytes(input string nm, input logic [7:0] hi,
                               input logic [7:0] lo);
        logic [7:0] exp [4];
        bit bad;
        exp = '{hi, lo, 8'h0D, 8'h0A};
        bad = 1'b0;
        checks++;
        if (rx_q.size() != NCH || mon_bad != 0) begin
            bad = 1'b1;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (rx_q[i] !== exp[i]) bad = 1'b1;
            end
        end
        if (bad) begin
            errors++;
            $display("FAIL %s bytes: got %p framing_errs %0d required %p (first %0d)",
                     nm, rx_q, mon_bad, exp, NCH);
        end
        rx_q.delete();
        mon_bad = 0;
    endtask

    // Cycle-exact frame check from the 8N1 definition.
    task automatic run_frame(input logic [7:0] v, input bit at_start,
                             input int max_wait, output int waited);
        logic [7:0] eb [4];
        int   bad;
        int   k;
        int   b;
        logic lvl;
        logic fd_exp;
        eb = '{hexc(v[7:4]), hexc(v[3:0]), 8'h0D, 8'h0A};
        waited = 0;
        wave_pos = -1;
        if (!at_start) begin
            @(negedge clk);
            while (tx !== 1'b0 && waited < max_wait) begin
                waited++;
                @(negedge clk);
            end
            checks++;
            if (tx !== 1'b0) begin
                errors++;
                $display("FAIL start_timeout v=%02h: tx=%b required 0", v, tx);
                return;
            end
        end
        bad = 0;
        for (int i = 0; i < FLEN; i++) begin
            if (i > 0) @(negedge clk);
            wave_pos = i;
            k = i / (10 * BC);
            b = (i % (10 * BC)) / BC;
            if (b == 0) lvl = 1'b0;
            else if (b == 9) lvl = 1'b1;
            else lvl = eb[k][b-1];
            fd_exp = (i == FLEN - 1) ? 1'b1 : 1'b0;
            if (tx !== lvl || busy !== 1'b1 || frame_done !== fd_exp) begin
                if (bad == 0)
                    $display("  first diff v=%02h cycle %0d tx=%b/%b busy=%b fd=%b/%b",
                             v, i, tx, lvl, busy, frame_done, fd_exp);
                bad++;
            end
        end
        chk("frame_wave", bad, 0);
        @(negedge clk);
        wave_pos = FLEN;
        if (exp_more) begin
            chk("b2b_after", {29'd0, tx, busy, frame_done}, 32'b010);
        end else begin
            chk("idle_after", {29'd0, tx, busy, frame_done}, 32'b100);
        end
    endtask

    task automatic wait_pos(input int p);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (wave_pos != p && n < 4 * FLEN);
        chk("stim_align", wave_pos, p);
    endtask

    task automatic rand_stim();
        int n;
        int t;
        logic [7:0] nv;
        n = $urandom_range(0, 3);
        t = 0;
        for (int j = 0; j < n; j++) begin
            t += $urandom_range(1, (FLEN - 30) / 3);
            wait_pos(t);
            nv = 8'($urandom);
            if (nv !== value) exp_more = 1'b1;
            value = nv;
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    vec_t       tbl [6];
    int         w;
    int         bad;
    int         n;
    logic [7:0] cur;
    logic [7:0] nv;
    bit         at_start;

    initial begin
        tbl[0] = '{8'h3A, 8'h33, 8'h41};
        tbl[1] = '{8'h09, 8'h30, 8'h39};
        tbl[2] = '{8'hA0, 8'h41, 8'h30};
        tbl[3] = '{8'hFF, 8'h46, 8'h46};
        tbl[4] = '{8'h5C, 8'h35, 8'h43};
        tbl[5] = '{8'h7E, 8'h37, 8'h45};

        // Reset state, then first frame reports the value present at release.
        rst = 1'b1;
        value = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_tx", tx, 1);
        chk("reset_busy", busy, 0);
        chk("reset_fd", frame_done, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rel_tx", tx, 1);
        chk("rel_busy", busy, 1);
        exp_more = 1'b0;
        run_frame(8'h00, 1'b0, 10, w);
        chk("first_latency", w, 0);
        check_bytes("first", 8'h30, 8'h30);

        // Single frames from idle.
        for (int i = 0; i < 6; i++) begin
            value = tbl[i].v;
            run_frame(tbl[i].v, 1'b0, 10, w);
            chk("idle_latency", w, 2);
            check_bytes("table", tbl[i].hi, tbl[i].lo);
        end

        // Coalescing: several changes mid-frame give one back-to-back frame.
        value = 8'h10;
        exp_more = 1'b1;
        fork
            run_frame(8'h10, 1'b0, 10, w);
            begin
                wait_pos(50);
                value = 8'h01;
                wait_pos(100);
                value = 8'h02;
                wait_pos(150);
                value = 8'h05;
            end
        join
        check_bytes("coalesce1", 8'h31, 8'h30);
        exp_more = 1'b0;
        run_frame(8'h05, 1'b1, 0, w);
        check_bytes("coalesce2", 8'h30, 8'h35);

        // Constant value: line stays quiet.
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) bad++;
        end
        chk("quiet_cycles", bad, 0);
        chk("quiet_bytes", rx_q.size(), 0);

        // Reset in the middle of a data bit abandons the frame.
        value = 8'h77;
        n = 0;
        while (tx !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rst_frame_start", tx, 0);
        repeat (BC + BC + BC / 2) @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        #2 rst = 1'b0;
        value = 8'hC4;
        rx_q.delete();
        mon_bad = 0;
        exp_more = 1'b0;
        run_frame(8'hC4, 1'b0, 10, w);
        chk("rst_latency", w, 1);
        check_bytes("after_rst", 8'h43, 8'h34);

        // Random changes against the coalescing model.
        cur = value;
        at_start = 1'b0;
        for (int r = 0; r < 8; r++) begin
            if (!at_start) begin
                do nv = 8'($urandom); while (nv == value);
                value = nv;
                cur = nv;
            end
            exp_more = 1'b0;
            fork
                run_frame(cur, at_start, 10, w);
                rand_stim();
            join
            if (!at_start) chk("rand_latency", w, 2);
            check_bytes("rand", hexc(cur[7:4]), hexc(cur[3:0]));
            if (exp_more) begin
                cur = value;
                at_start = 1'b1;
            end else begin
                at_start = 1'b0;
            end
        end
        if (at_start) begin
            exp_more = 1'b0;
            run_frame(cur, 1'b1, 0, w);
            check_bytes("rand_tail", hexc(cur[7:4]), hexc(cur[3:0]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
